// File: rtl/dmb_link_pkg.sv
// ---------------------------------------------------------------------------
// dmb_link_pkg
// Shared definitions for the link transmit and receive paths:
//   - 8b/10b octet constants (K- and D-characters) used to build line words
//   - composed 16-bit line words (low octet goes out first)
//   - transmit state encoding
//   - byte-wise reflected CRC-32 step function
// ---------------------------------------------------------------------------
package dmb_link_pkg;

    // Octet constants
    localparam logic [7:0] K28_5    = 8'hBC;  // comma / idle
    localparam logic [7:0] K27_7    = 8'hFB;  // start of packet
    localparam logic [7:0] K29_7    = 8'hFD;  // end of packet
    localparam logic [7:0] K23_7    = 8'hF7;  // carrier extend
    localparam logic [7:0] K30_7    = 8'hFE;  // error propagation
    localparam logic [7:0] D16_2    = 8'h50;  // idle filler data octet
    localparam logic [7:0] PRMBL    = 8'h55;  // preamble octet
    localparam logic [7:0] SOF_BYTE = 8'hD5;  // start-of-frame delimiter

    // Line words: {second octet, first octet}
    localparam logic [15:0] W_IDLE = {D16_2, K28_5};
    localparam logic [15:0] W_PRE1 = {PRMBL, K27_7};
    localparam logic [15:0] W_PRE  = {PRMBL, PRMBL};
    localparam logic [15:0] W_SOF  = {SOF_BYTE, PRMBL};
    localparam logic [15:0] W_VERR = {K30_7, K30_7};
    localparam logic [15:0] W_EOP  = {K23_7, K29_7};
    localparam logic [15:0] W_EXT  = {K23_7, K23_7};

    typedef enum logic [3:0] {
        IDLE, PRE1, PRE2, PRE3, SOF, DATA,
        CRC_LO, CRC_HI, VERR, EOP, EXT, IPG
    } tx_state_e;

    // Reflected form of polynomial 04C11DB7
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

    // One byte through the LSB-first CRC-32 register
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_tx16.sv
// ---------------------------------------------------------------------------
// crc32_tx16
// CRC-32 (Ethernet) accumulator taking one 16-bit word per cycle, low byte
// first. Shared by transmit and receive paths.
//   clk   : clock
//   rst_n : asynchronous active-low reset (register preset to all ones)
//   init  : preset the register to FFFFFFFF
//   calc  : fold d into the register (ignored while init is high)
//   d     : data word, d[7:0] processed before d[15:8]
//   crc   : complemented register value, ready to transmit
// ---------------------------------------------------------------------------
module crc32_tx16
    import dmb_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        calc,
    input  logic [15:0] d,
    output logic [31:0] crc
);

    logic [31:0] crc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= '1;
        end else if (init) begin
            crc_reg <= '1;
        end else if (calc) begin
            crc_reg <= crc32_byte(crc32_byte(crc_reg, d[7:0]), d[15:8]);
        end
    end

    assign crc = ~crc_reg;

endmodule

// File: rtl/tx_frame_gen.sv
// ---------------------------------------------------------------------------
// tx_frame_gen
// Wraps client payload words into a framed 16-bit PCS/PMA transmit stream:
// preamble, SOF, payload, CRC-32, EOP, carrier extend, inter-packet gap.
// Every output word is registered: the word for the state held in cycle t
// appears in cycle t+1.
//   CLK        : clock
//   RST_N      : asynchronous active-low reset
//   TX_DATA_IN : client payload word, [7:0] transmitted first
//   TX_DV      : client word valid; requests a frame while idle
//   TX_LAST    : current word is the final payload word
//   TX_ACK     : word accepted this cycle when TX_DV is also high
//   TXDATA     : transmit word
//   TX_IS_K    : K-flags, bit0 covers TXDATA[7:0]
//   TX_BUSY    : high on every word from PRE1 through EXT
//   TX_ERR     : one-cycle pulse on underrun or length overflow
// ---------------------------------------------------------------------------
module tx_frame_gen
    import dmb_link_pkg::*;
#(
    parameter int MAX_WORDS = 812,
    parameter int IPG_WORDS = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] TX_DATA_IN,
    input  logic        TX_DV,
    input  logic        TX_LAST,
    output logic        TX_ACK,
    output logic [15:0] TXDATA,
    output logic [1:0]  TX_IS_K,
    output logic        TX_BUSY,
    output logic        TX_ERR
);

    localparam logic [12:0] MAX_CNT  = 13'(MAX_WORDS);
    localparam logic [5:0]  IPG_LOAD = 6'(IPG_WORDS - 1);

    tx_state_e   state;
    logic [11:0] word_cnt;
    logic [12:0] word_cnt_inc;
    logic [5:0]  ipg_cnt;
    logic [31:0] crc_val;

    assign TX_ACK       = (state == DATA);
    assign word_cnt_inc = {1'b0, word_cnt} + 13'd1;

    crc32_tx16 u_crc (
        .clk   (CLK),
        .rst_n (RST_N),
        .init  (state == PRE1),
        .calc  ((state == DATA) && TX_DV),
        .d     (TX_DATA_IN),
        .crc   (crc_val)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            word_cnt <= '0;
            ipg_cnt  <= IPG_LOAD;   // a reset counts as a full gap still to run
            TXDATA   <= W_IDLE;
            TX_IS_K  <= 2'b01;
            TX_BUSY  <= 1'b0;
            TX_ERR   <= 1'b0;
        end else begin
            TX_ERR  <= 1'b0;
            TX_BUSY <= (state != IDLE) && (state != IPG);
            case (state)
                IDLE: begin
                    TXDATA  <= W_IDLE;
                    TX_IS_K <= 2'b01;
                    if (ipg_cnt != '0) begin
                        ipg_cnt <= ipg_cnt - 6'd1;
                    end else if (TX_DV) begin
                        state <= PRE1;
                    end
                end
                PRE1: begin
                    TXDATA   <= W_PRE1;
                    TX_IS_K  <= 2'b01;
                    word_cnt <= '0;
                    state    <= PRE2;
                end
                PRE2: begin
                    TXDATA  <= W_PRE;
                    TX_IS_K <= 2'b00;
                    state   <= PRE3;
                end
                PRE3: begin
                    TXDATA  <= W_PRE;
                    TX_IS_K <= 2'b00;
                    state   <= SOF;
                end
                SOF: begin
                    TXDATA  <= W_SOF;
                    TX_IS_K <= 2'b00;
                    state   <= DATA;
                end
                DATA: begin
                    if (TX_DV) begin
                        TXDATA  <= TX_DATA_IN;
                        TX_IS_K <= 2'b00;
                        if (word_cnt != '1) begin
                            word_cnt <= word_cnt_inc[11:0];
                        end
                        if (TX_LAST) begin
                            state <= CRC_LO;
                        end else if (word_cnt_inc >= MAX_CNT) begin
                            // Overlong frame: close it cleanly but flag it
                            state  <= CRC_LO;
                            TX_ERR <= 1'b1;
                        end
                    end else begin
                        // Underrun: nothing valid to send, so the error
                        // symbol goes out immediately and VERR repeats it
                        TXDATA  <= W_VERR;
                        TX_IS_K <= 2'b11;
                        TX_ERR  <= 1'b1;
                        state   <= VERR;
                    end
                end
                CRC_LO: begin
                    TXDATA  <= crc_val[15:0];
                    TX_IS_K <= 2'b00;
                    state   <= CRC_HI;
                end
                CRC_HI: begin
                    TXDATA  <= crc_val[31:16];
                    TX_IS_K <= 2'b00;
                    state   <= EOP;
                end
                VERR: begin
                    TXDATA  <= W_VERR;
                    TX_IS_K <= 2'b11;
                    state   <= EOP;
                end
                EOP: begin
                    TXDATA  <= W_EOP;
                    TX_IS_K <= 2'b11;
                    state   <= EXT;
                end
                EXT: begin
                    TXDATA  <= W_EXT;
                    TX_IS_K <= 2'b11;
                    ipg_cnt <= IPG_LOAD;
                    // IDLE always contributes one idle word before PRE1, so
                    // IPG covers the remaining IPG_WORDS-1 words; a one-word
                    // gap therefore needs no IPG state at all.
                    state   <= (IPG_LOAD == '0) ? IDLE : IPG;
                end
                IPG: begin
                    TXDATA  <= W_IDLE;
                    TX_IS_K <= 2'b01;
                    if (ipg_cnt <= 6'd1) begin
                        ipg_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        ipg_cnt <= ipg_cnt - 6'd1;
                    end
                end
                default: begin
                    TXDATA  <= W_IDLE;
                    TX_IS_K <= 2'b01;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_gen.sv
module tb_tx_frame_gen;

    localparam int MAXW = 812;
    localparam int IPGW = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tx_data_in;
    logic        tx_dv;
    logic        tx_last;
    logic        tx_ack;
    logic [15:0] txdata;
    logic [1:0]  tx_is_k;
    logic        tx_busy;
    logic        tx_err;

    tx_frame_gen #(.MAX_WORDS(MAXW), .IPG_WORDS(IPGW)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .TX_DATA_IN (tx_data_in),
        .TX_DV      (tx_dv),
        .TX_LAST    (tx_last),
        .TX_ACK     (tx_ack),
        .TXDATA     (txdata),
        .TX_IS_K    (tx_is_k),
        .TX_BUSY    (tx_busy),
        .TX_ERR     (tx_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] crc_tbl [0:255];
    logic [15:0] pay [0:1023];

    function automatic logic [31:0] crc_b(input logic [31:0] c, input logic [7:0] b);
        logic [7:0] ix;
        ix = c[7:0] ^ b;
        return crc_tbl[ix] ^ (c >> 8);
    endfunction

    // Expected {K,word} sequence of one frame from PRE1 through EXT
    task automatic build_exp(input int n, input bit underrun, output logic [17:0] q[$]);
        logic [31:0] c;
        q = {};
        q.push_back({2'b01, 16'h55FB});
        q.push_back({2'b00, 16'h5555});
        q.push_back({2'b00, 16'h5555});
        q.push_back({2'b00, 16'hD555});
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            q.push_back({2'b00, pay[i]});
            c = crc_b(crc_b(c, pay[i][7:0]), pay[i][15:8]);
        end
        if (underrun) begin
            q.push_back({2'b11, 16'hFEFE});
            q.push_back({2'b11, 16'hFEFE});
        end else begin
            c = ~c;
            q.push_back({2'b00, c[15:0]});
            q.push_back({2'b00, c[31:16]});
        end
        q.push_back({2'b11, 16'hF7FD});
        q.push_back({2'b11, 16'hF7F7});
    endtask

    // ---------------- output monitor ----------------
    typedef struct packed {
        logic [1:0]  k;
        logic [15:0] d;
        logic        busy;
        logic        err;
    } ent_t;
    ent_t log_q[$];

    always @(negedge clk) begin
        log_q.push_back('{k: tx_is_k, d: txdata, busy: tx_busy, err: tx_err});
    end

    task automatic analyze(input logic [17:0] exp_q[$], input int from, input int exp_err,
                           output int sof_idx, output int end_idx);
        int s, busy_n, err_n, len;
        s = -1;
        for (int i = from; i < log_q.size(); i++) begin
            if (s < 0 && log_q[i].k == 2'b01 && log_q[i].d == 16'h55FB) s = i;
        end
        sof_idx = s;
        end_idx = log_q.size();
        len = exp_q.size();
        check("sof_found", 32'(s >= 0), 32'd1);
        if (s >= 0) begin
            if (s + len >= log_q.size()) begin
                check("frame_len", 32'(log_q.size()), 32'(s + len + 1));
            end else begin
                busy_n = 0;
                err_n  = 0;
                for (int j = 0; j < len; j++) begin
                    check($sformatf("word%0d", j), {14'h0, log_q[s+j].k, log_q[s+j].d}, {14'h0, exp_q[j]});
                    busy_n += int'(log_q[s+j].busy);
                    err_n  += int'(log_q[s+j].err);
                end
                check("busy_words", 32'(busy_n), 32'(len));
                check("err_pulses", 32'(err_n), 32'(exp_err));
                check("post_idle", {14'h0, log_q[s+len].k, log_q[s+len].d}, {14'h0, 2'b01, 16'h50BC});
                check("post_busy", 32'(log_q[s+len].busy), 32'd0);
                end_idx = s + len;
            end
        end
    endtask

    // ---------------- client driver ----------------
    task automatic present(input int idx, input int n, input int drop_at, input bit use_last);
        tx_dv      = (idx != drop_at) && (idx < n);
        tx_data_in = (idx < 1024) ? pay[idx] : 16'h0;
        tx_last    = use_last && (idx == n - 1);
    endtask

    task automatic send_frame(input int n, input int drop_at, input bit use_last,
                              input bit keep_dv, output int acked);
        int  idx, guard;
        bit  done, ack_now, acc;
        idx = 0; guard = 0; done = 0;
        present(idx, n, drop_at, use_last);
        while (!done && guard < 2000) begin
            @(negedge clk);
            ack_now = tx_ack;
            acc     = tx_ack && tx_dv;
            @(posedge clk); #1;
            guard++;
            if (acc) idx++;
            if (ack_now && !tx_ack) done = 1;
            if (done) begin
                tx_dv   = keep_dv;
                tx_last = 1'b0;
            end else begin
                present(idx, n, drop_at, use_last);
            end
        end
        check("frame_end_seen", 32'(done), 32'd1);
        acked = idx;
    endtask

    task automatic settle();
        repeat (IPGW + 12) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [17:0] exp_q[$];
        logic [17:0] exp_a[$];
        int acked, s, e, s2, e2, rel_idx, n, drop, idle_n, eop_n;

        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[i] = c;
        end

        // Reset state
        rst_n = 1'b0; tx_dv = 1'b0; tx_last = 1'b0; tx_data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_txdata", 32'(txdata), 32'h50BC);
        check("rst_isk",    32'(tx_is_k), 32'h1);
        check("rst_ack",    32'(tx_ack), 32'h0);
        check("rst_busy",   32'(tx_busy), 32'h0);
        check("rst_err",    32'(tx_err), 32'h0);
        rst_n = 1'b1;
        settle();

        // 3-word directed frame
        log_q.delete();
        pay[0] = 16'h0001; pay[1] = 16'h0002; pay[2] = 16'h0003;
        build_exp(3, 0, exp_q);
        send_frame(3, -1, 1, 0, acked);
        settle();
        check("acked_3w", 32'(acked), 32'd3);
        analyze(exp_q, 0, 0, s, e);
        idle_n = 0;
        for (int i = e; i < log_q.size(); i++) if (log_q[i].d == 16'h50BC && log_q[i].k == 2'b01) idle_n++;
        check("idle_after_3w", 32'(idle_n >= IPGW), 32'd1);
        $display("frame 3w: acked %0d", acked);

        // Zero payload CRC
        log_q.delete();
        for (int i = 0; i < 4; i++) pay[i] = 16'h0000;
        build_exp(4, 0, exp_q);
        send_frame(4, -1, 1, 0, acked);
        settle();
        check("acked_zero", 32'(acked), 32'd4);
        analyze(exp_q, 0, 0, s, e);
        $display("frame zero4: acked %0d", acked);

        // Random frames
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) pay[i] = 16'($urandom);
            log_q.delete();
            build_exp(n, 0, exp_q);
            send_frame(n, -1, 1, 0, acked);
            settle();
            check("acked_rand", 32'(acked), 32'(n));
            analyze(exp_q, 0, 0, s, e);
            $display("frame rand%0d: len %0d acked %0d", f, n, acked);
        end

        // Underrun after two words, then a random-position underrun
        for (int f = 0; f < 2; f++) begin
            n    = (f == 0) ? 6 : $urandom_range(3, 12);
            drop = (f == 0) ? 2 : $urandom_range(1, n - 1);
            for (int i = 0; i < n; i++) pay[i] = 16'($urandom);
            log_q.delete();
            build_exp(drop, 1, exp_q);
            send_frame(n, drop, 1, 0, acked);
            settle();
            check("acked_underrun", 32'(acked), 32'(drop));
            analyze(exp_q, 0, 1, s, e);
            $display("frame underrun: drop at %0d acked %0d", drop, acked);
        end

        // Back-to-back with TX_DV held high
        log_q.delete();
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) pay[i] = 16'($urandom);
        build_exp(n, 0, exp_a);
        send_frame(n, -1, 1, 1, acked);
        check("acked_b2b_a", 32'(acked), 32'(n));
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) pay[i] = 16'($urandom);
        build_exp(n, 0, exp_q);
        send_frame(n, -1, 1, 0, acked);
        settle();
        check("acked_b2b_b", 32'(acked), 32'(n));
        analyze(exp_a, 0, 0, s, e);
        analyze(exp_q, e, 0, s2, e2);
        check("ipg_gap", 32'(s2 - e), 32'(IPGW));
        $display("frame b2b: gap %0d", s2 - e);

        // Overflow: 813 words offered, no TX_LAST
        log_q.delete();
        for (int i = 0; i < MAXW + 1; i++) pay[i] = 16'($urandom);
        build_exp(MAXW, 0, exp_q);
        send_frame(MAXW + 1, -1, 0, 1, acked);
        tx_data_in = pay[MAXW];
        @(negedge clk);
        check("no_ack_813", 32'(tx_ack), 32'd0);
        tx_dv = 1'b0;
        settle();
        check("acked_overflow", 32'(acked), 32'(MAXW));
        analyze(exp_q, 0, 1, s, e);
        $display("frame overflow: acked %0d", acked);

        // Reset during payload word 5
        for (int i = 0; i < 10; i++) pay[i] = 16'($urandom);
        acked = 0;
        present(0, 10, -1, 0);
        for (int g = 0; g < 100; g++) begin
            bit acc;
            @(negedge clk);
            if (tx_ack && acked == 4) break;
            acc = tx_ack && tx_dv;
            @(posedge clk); #1;
            if (acc) acked++;
            present(acked, 10, -1, 0);
        end
        check("reached_word5", 32'(tx_ack && acked == 4), 32'd1);
        log_q.delete();
        rst_n = 1'b0;
        #1;
        check("abort_txdata", 32'(txdata), 32'h50BC);
        check("abort_isk",    32'(tx_is_k), 32'h1);
        check("abort_busy",   32'(tx_busy), 32'h0);
        @(negedge clk);
        check("abort_next_txdata", 32'(txdata), 32'h50BC);
        @(negedge clk);
        rel_idx = log_q.size();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) pay[i] = 16'($urandom);
        build_exp(3, 0, exp_q);
        send_frame(3, -1, 1, 0, acked);
        settle();
        analyze(exp_q, 0, 0, s, e);
        idle_n = 0; eop_n = 0;
        for (int i = 0; i < ((s < 0) ? log_q.size() : s); i++) begin
            if (log_q[i].d == 16'hF7FD) eop_n++;
            if (i >= rel_idx && log_q[i].d == 16'h50BC && log_q[i].k == 2'b01) idle_n++;
        end
        check("abort_no_eop", 32'(eop_n), 32'd0);
        check("abort_full_ipg", 32'(idle_n >= IPGW), 32'd1);
        $display("frame after reset: idle words %0d acked %0d", idle_n, acked);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_frame_gen.md
TX_FRAME_GEN -- requirements
Module: tx_frame_gen

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 812: maximum payload words per frame.
REQ-002 SHALL have parameter IPG_WORDS, default 6: minimum idle words between frames, range 1..63.
REQ-003 SHALL have port CLK  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port TX_DATA_IN  in  16  client payload word; bits 7:0 go out first.
REQ-006 SHALL have port TX_DV  in  1  client word valid; a high level in IDLE requests a frame.
REQ-007 SHALL have port TX_LAST  in  1  qualifies TX_DV: the current word is the final payload word.
REQ-008 SHALL have port TX_ACK  out  1  word accepted this cycle (TX_DV && TX_ACK).
REQ-009 SHALL have port TXDATA  out  16  registered PCS/PMA transmit word.
REQ-010 SHALL have port TX_IS_K  out  2  registered K-flags; bit0 covers TXDATA[7:0].
REQ-011 SHALL have port TX_BUSY  out  1  high from the PRE1 word through the last EXT word.
REQ-012 SHALL have port TX_ERR  out  1  one-cycle pulse on underrun or length overflow.

Function
REQ-013 SHALL use the states IDLE, PRE1, PRE2, PRE3, SOF, DATA, CRC_LO, CRC_HI, VERR, EOP, EXT and IPG.
REQ-014 Each state SHALL drive one word: IDLE/IPG 16'h50BC K=01; PRE1 16'h55FB K=01; PRE2/PRE3 16'h5555 K=00; SOF 16'hD555 K=00.
REQ-015 The remaining states SHALL drive: DATA the accepted payload K=00; CRC_LO/CRC_HI CRC[15:0]/CRC[31:16] K=00; VERR 16'hFEFE K=11; EOP 16'hF7FD K=11; EXT 16'hF7F7 K=11.
REQ-016 The word for the state held in cycle t SHALL appear on TXDATA/TX_IS_K in cycle t+1 (one-cycle latency).
REQ-017 IDLE SHALL go to PRE1 when TX_DV=1 and the IPG counter is 0; otherwise it stays in IDLE.
REQ-018 PRE1, PRE2, PRE3 and SOF SHALL each advance after one cycle, in that order, ending in DATA.
REQ-019 TX_ACK SHALL equal (state==DATA) combinationally; it is never high in any other state.
REQ-020 In DATA with TX_DV=1, the word SHALL be accepted, the CRC updated and the word count incremented.
REQ-021 In DATA, TX_LAST=1 or word count reaching MAX_WORDS SHALL go to CRC_LO.
REQ-022 If DATA exits on MAX_WORDS without TX_LAST, TX_ERR SHALL pulse and the frame SHALL still close with a valid CRC.
REQ-023 In DATA with TX_DV=0 (underrun), TX_ERR SHALL pulse, the state SHALL go to VERR then EOP, and no CRC SHALL be sent.
REQ-024 CRC_LO SHALL go to CRC_HI, then EOP, then EXT, then IPG.
REQ-025 IPG SHALL load its counter with IPG_WORDS-1, count down each cycle, and go to IDLE at 0.
REQ-026 The CRC SHALL be CRC-32 (poly 04C11DB7, reflected), init FFFFFFFF at PRE1, with the final value complemented; it covers payload only.
REQ-027 The CRC SHALL process each 16-bit word as byte [7:0] first, then byte [15:8].
REQ-028 The word counter SHALL be 12 bits, cleared at PRE1, and SHALL never wrap.
REQ-029 TX_DV arriving during the IPG/EXT states SHALL be held off; the frame starts only from IDLE.

Reset
REQ-030 RST_N low SHALL set the state to IDLE, TXDATA=16'h50BC, TX_IS_K=2'b01, and TX_ACK, TX_BUSY and TX_ERR to 0.
REQ-031 RST_N low SHALL clear the word count and load the IPG counter with IPG_WORDS-1.
REQ-032 Reset mid-frame SHALL abort the frame with no EOP, and the full IPG SHALL elapse before the next PRE1.

Structure
REQ-033 Octet constants (K28_5, K27_7, K29_7, K23_7, K30_7, D16_2, PRMBL, SOF_BYTE) and the state encoding SHALL live in the shared package dmb_link_pkg.
REQ-034 The CRC SHALL be one sub-module, crc32_tx16 (init, calc, 16-bit d, 32-bit crc out), reusable by the receive side.

Verification
REQ-035 3-word frame 0001/0002/0003, LAST on word 3 -> the words below appear, and the receive path reports GOOD_CRC=1.
  - Words in order: 55FB, 5555, 5555, D555, 0001, 0002, 0003, CRC_LO, CRC_HI, F7FD, F7F7.
  - Then 6 or more words of 50BC.
REQ-036 TX_DV held high across two frames -> exactly IPG_WORDS 50BC words between EXT and the second 55FB.
REQ-037 TX_DV dropped after 2 payload words -> FEFE K=11, then F7FD, with a one-cycle TX_ERR pulse.
REQ-038 813 words without TX_LAST -> 812 words sent, then CRC and EOP, with a TX_ERR pulse; word 813 is not acked.
REQ-039 RST_N pulsed low during word 5 of DATA -> next cycle 50BC K=01, and no F7FD is sent.
REQ-040 Zero-data CRC check: 4 words of 0000 -> CRC words equal the model value for 8 zero bytes, FFFF/FFFF complement applied.
